// File: rtl/pattern_scheduler_pkg.sv
// Shared types and constants for the pattern scheduler slice:
// pattern indices, the pattern index type, the scheduler state
// encoding and a helper that computes the wrapped next pattern.
package pattern_pkg;

    typedef logic [1:0] pattern_t;

    localparam pattern_t PATTERN_CHECKERBOARD = 2'd0;
    localparam pattern_t PATTERN_RADIENT      = 2'd1;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } sched_state_t;

    // Next pattern index, wrapping from num-1 back to the first pattern
    function automatic pattern_t next_pattern(input pattern_t cur, input int unsigned num);
        if (cur == pattern_t'(num - 1))
            return PATTERN_CHECKERBOARD;
        else
            return cur + 2'd1;
    endfunction

endpackage

// File: rtl/pattern_scheduler_if.sv
// Board-side control bundle of the pattern scheduler: frame pulse,
// raw button and mode switch in, pattern index and flags out.
// master = board/timing side, slave = the scheduler itself.
interface pattern_scheduler_if;
    import pattern_pkg::*;

    logic     next_frame;
    logic     btn_raw;
    logic     auto_mode;
    pattern_t pattern_select;
    logic     blank;
    logic     advanced;

    modport master (
        output next_frame, btn_raw, auto_mode,
        input  pattern_select, blank, advanced
    );

    modport slave (
        input  next_frame, btn_raw, auto_mode,
        output pattern_select, blank, advanced
    );

endinterface

// File: rtl/pattern_scheduler_button_debounce.sv
// Push-button conditioning: 2-FF synchroniser, stable-count debouncer
// and a one-cycle pulse on each accepted 0->1 transition.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync_1;
    logic             sync_2;
    logic             db_level;
    logic             db_level_q;
    logic [CNT_W-1:0] stable_cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level   <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_2 != db_level) begin
            if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level   <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            db_level_q <= 1'b0;
        else
            db_level_q <= db_level;
    end

    assign press = db_level & ~db_level_q;

endmodule

// File: rtl/pattern_scheduler.sv
// Pattern scheduler: steps pattern_select on frame boundaries, either
// every FRAMES_PER_PATTERN frames (auto mode) or on a debounced button
// press. Optional post-change blanking is compiled in with the macro
// PATTERN_SCHED_BLANK_EN; without it blank is tied low and the block
// never leaves SHOW.
module pattern_scheduler
    import pattern_pkg::*;
#(
    parameter int NUM_PATTERNS       = 2,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int BLANK_FRAMES       = 2,
    parameter int DEBOUNCE_CYCLES    = 250000
) (
    input  logic                clk,
    input  logic                rst_n,
    pattern_scheduler_if.slave  ctrl
);

    localparam int FCNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

    logic              press;
    logic              auto_s1;
    logic              auto_s2;
    logic              auto_q;
    logic              auto_chg;
    logic              expire;
    logic              req;
    logic              req_n;
    logic [FCNT_W-1:0] fcnt;
    logic [FCNT_W-1:0] fcnt_n;
    pattern_t          sel;
    pattern_t          sel_n;
    logic              adv_r;
    logic              adv_n;
    sched_state_t      state;
    sched_state_t      state_n;

`ifdef PATTERN_SCHED_BLANK_EN
    localparam int BCNT_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_n;
    logic              blank_r;
    logic              blank_n;
`endif

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (ctrl.btn_raw),
        .press   (press)
    );

    // Synchronise the mode switch and keep a delayed copy to spot changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_s1 <= 1'b0;
            auto_s2 <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            auto_s1 <= ctrl.auto_mode;
            auto_s2 <= auto_s1;
            auto_q  <= auto_s2;
        end
    end

    assign auto_chg = auto_s2 ^ auto_q;
    assign expire   = auto_s2 && (fcnt == FCNT_W'(FRAMES_PER_PATTERN - 1));

    // Scheduler state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SHOW;
        else
            state <= state_n;
    end

    // Next state and next values of the pattern, counters, request and flags
    always_comb begin
        state_n = state;
        sel_n   = sel;
        adv_n   = 1'b0;
        fcnt_n  = fcnt;
        req_n   = req | press;
`ifdef PATTERN_SCHED_BLANK_EN
        bcnt_n  = bcnt;
        blank_n = blank_r;
`endif
        case (state)
            SHOW: begin
                if (ctrl.next_frame) begin
                    if (req || expire) begin
                        sel_n  = next_pattern(sel, NUM_PATTERNS);
                        fcnt_n = '0;
                        req_n  = press;
                        adv_n  = 1'b1;
`ifdef PATTERN_SCHED_BLANK_EN
                        blank_n = 1'b1;
                        bcnt_n  = '0;
                        state_n = BLANK;
`endif
                    end else begin
                        fcnt_n = fcnt + 1'b1;
                    end
                end
            end
`ifdef PATTERN_SCHED_BLANK_EN
            BLANK: begin
                fcnt_n = '0;
                if (ctrl.next_frame) begin
                    if (bcnt == BCNT_W'(BLANK_FRAMES - 1)) begin
                        bcnt_n  = '0;
                        blank_n = 1'b0;
                        state_n = SHOW;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_n = SHOW;
            end
        endcase
        if (!auto_s2 || auto_chg)
            fcnt_n = '0;
    end

    // Datapath registers: pattern, frame counter, pending request, advance pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel   <= PATTERN_CHECKERBOARD;
            fcnt  <= '0;
            req   <= 1'b0;
            adv_r <= 1'b0;
        end else begin
            sel   <= sel_n;
            fcnt  <= fcnt_n;
            req   <= req_n;
            adv_r <= adv_n;
        end
    end

`ifdef PATTERN_SCHED_BLANK_EN
    // Blanking counter and flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt    <= '0;
            blank_r <= 1'b0;
        end else begin
            bcnt    <= bcnt_n;
            blank_r <= blank_n;
        end
    end

    assign ctrl.blank = blank_r;
`else
    assign ctrl.blank = 1'b0;
`endif

    assign ctrl.pattern_select = sel;
    assign ctrl.advanced       = adv_r;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed testbench for pattern_scheduler with NUM_PATTERNS=2,
// FRAMES_PER_PATTERN=4, BLANK_FRAMES=2, DEBOUNCE_CYCLES=8 and a
// next_frame pulse every 50 clocks. Expectations follow whether
// PATTERN_SCHED_BLANK_EN is defined for the build.
module tb_pattern_scheduler;
    import pattern_pkg::*;

`ifdef PATTERN_SCHED_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    localparam int AUTO_PERIOD = BLANK_EN ? 6 : 4;

    logic clk;
    logic rst_n;
    int   nchk;
    int   nfail;
    int   adv_seen;
    int   midframe;
    pattern_t last_sel;

    pattern_scheduler_if bus ();

    pattern_scheduler #(
        .NUM_PATTERNS       (2),
        .FRAMES_PER_PATTERN (4),
        .BLANK_FRAMES       (2),
        .DEBOUNCE_CYCLES    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus.slave)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count advance pulses and any pattern change not caused by a frame pulse
    initial begin
        adv_seen = 0;
        midframe = 0;
        last_sel = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                last_sel = 2'd0;
            end else begin
                if (bus.pattern_select != last_sel && !bus.next_frame)
                    midframe++;
                last_sel = bus.pattern_select;
                if (bus.advanced)
                    adv_seen++;
            end
        end
    end

    // Idle for n cycles, inputs change on falling edges
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rest of a 50-cycle frame after 'used' cycles, then the pulse;
    // returns outputs right after the pulse and advanced one cycle later
    task automatic frame(input int used, output pattern_t s, output logic b,
                         output logic a, output logic a2);
        tick(48 - used);
        bus.next_frame = 1'b1;
        @(negedge clk);
        bus.next_frame = 1'b0;
        s = bus.pattern_select;
        b = bus.blank;
        a = bus.advanced;
        @(negedge clk);
        a2 = bus.advanced;
    endtask

    task automatic press(input int hi, input int lo);
        bus.btn_raw = 1'b1;
        tick(hi);
        bus.btn_raw = 1'b0;
        tick(lo);
    endtask

    task automatic do_reset(input logic auto_lvl);
        @(negedge clk);
        bus.auto_mode  = auto_lvl;
        bus.btn_raw    = 1'b0;
        bus.next_frame = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        nchk++; if (bus.pattern_select !== 2'd0) begin nfail++; $display("[TB] FAIL reset_sel: got %0d expected 0", bus.pattern_select); end
        nchk++; if (bus.blank !== 1'b0) begin nfail++; $display("[TB] FAIL reset_blank: got %0b expected 0", bus.blank); end
        nchk++; if (bus.advanced !== 1'b0) begin nfail++; $display("[TB] FAIL reset_adv: got %0b expected 0", bus.advanced); end
    endtask

    task automatic test_auto_cycle();
        pattern_t s;
        logic b, a, a2;
        logic exp_b, exp_a;
        pattern_t exp_s;
        for (int f = 1; f <= 3; f++) begin
            frame(0, s, b, a, a2);
            nchk++; if (s !== 2'd0) begin nfail++; $display("[TB] FAIL auto_sel f%0d: got %0d expected 0", f, s); end
            nchk++; if (a !== 1'b0) begin nfail++; $display("[TB] FAIL auto_adv f%0d: got %0b expected 0", f, a); end
        end
        frame(0, s, b, a, a2);
        nchk++; if (s !== 2'd1) begin nfail++; $display("[TB] FAIL auto_sel f4: got %0d expected 1", s); end
        nchk++; if (a !== 1'b1) begin nfail++; $display("[TB] FAIL auto_adv f4: got %0b expected 1", a); end
        nchk++; if (a2 !== 1'b0) begin nfail++; $display("[TB] FAIL auto_adv_width f4: got %0b expected 0", a2); end
        nchk++; if (b !== BLANK_EN) begin nfail++; $display("[TB] FAIL auto_blank f4: got %0b expected %0b", b, BLANK_EN); end
        for (int f = 5; f <= 4 + AUTO_PERIOD; f++) begin
            frame(0, s, b, a, a2);
            exp_s = (f == 4 + AUTO_PERIOD) ? 2'd0 : 2'd1;
            exp_a = (f == 4 + AUTO_PERIOD);
            exp_b = BLANK_EN && (f == 5 || f == 4 + AUTO_PERIOD);
            nchk++; if (s !== exp_s) begin nfail++; $display("[TB] FAIL auto_sel f%0d: got %0d expected %0d", f, s, exp_s); end
            nchk++; if (a !== exp_a) begin nfail++; $display("[TB] FAIL auto_adv f%0d: got %0b expected %0b", f, a, exp_a); end
            nchk++; if (b !== exp_b) begin nfail++; $display("[TB] FAIL auto_blank f%0d: got %0b expected %0b", f, b, exp_b); end
        end
    endtask

    task automatic test_glitch_press();
        pattern_t s;
        logic b, a, a2;
        int base;
        do_reset(1'b0);
        base = adv_seen;
        for (int g = 0; g < 3; g++) press(5, 6);
        frame(33, s, b, a, a2);
        nchk++; if (s !== 2'd0) begin nfail++; $display("[TB] FAIL glitch_sel: got %0d expected 0", s); end
        press(20, 20);
        nchk++; if (bus.pattern_select !== 2'd0) begin nfail++; $display("[TB] FAIL press_midframe_sel: got %0d expected 0", bus.pattern_select); end
        frame(40, s, b, a, a2);
        nchk++; if (s !== 2'd1) begin nfail++; $display("[TB] FAIL press_sel: got %0d expected 1", s); end
        nchk++; if (a !== 1'b1) begin nfail++; $display("[TB] FAIL press_adv: got %0b expected 1", a); end
        frame(0, s, b, a, a2);
        nchk++; if (s !== 2'd1) begin nfail++; $display("[TB] FAIL press_hold_sel: got %0d expected 1", s); end
        nchk++; if (adv_seen - base !== 1) begin nfail++; $display("[TB] FAIL press_adv_count: got %0d expected 1", adv_seen - base); end
    endtask

    task automatic test_multi_press();
        pattern_t s;
        logic b, a, a2;
        int base;
        do_reset(1'b0);
        base = adv_seen;
        for (int p = 0; p < 3; p++) press(8, 8);
        frame(48, s, b, a, a2);
        nchk++; if (s !== 2'd1) begin nfail++; $display("[TB] FAIL multi_sel: got %0d expected 1", s); end
        for (int f = 0; f < 3; f++) begin
            frame(0, s, b, a, a2);
            nchk++; if (s !== 2'd1) begin nfail++; $display("[TB] FAIL multi_hold_sel f%0d: got %0d expected 1", f, s); end
        end
        nchk++; if (adv_seen - base !== 1) begin nfail++; $display("[TB] FAIL multi_adv_count: got %0d expected 1", adv_seen - base); end
    endtask

    task automatic test_press_during_blank();
        pattern_t s;
        logic b, a, a2;
        pattern_t exp_s;
        do_reset(1'b0);
        press(20, 20);
        frame(40, s, b, a, a2);
        nchk++; if (s !== 2'd1) begin nfail++; $display("[TB] FAIL blankpress_first_sel: got %0d expected 1", s); end
        frame(0, s, b, a, a2);
        press(20, 20);
        frame(40, s, b, a, a2);
        exp_s = BLANK_EN ? 2'd1 : 2'd0;
        nchk++; if (s !== exp_s) begin nfail++; $display("[TB] FAIL blankpress_end_sel: got %0d expected %0d", s, exp_s); end
        nchk++; if (b !== 1'b0) begin nfail++; $display("[TB] FAIL blankpress_end_blank: got %0b expected 0", b); end
        frame(0, s, b, a, a2);
        nchk++; if (s !== 2'd0) begin nfail++; $display("[TB] FAIL blankpress_next_sel: got %0d expected 0", s); end
        nchk++; if (a !== BLANK_EN) begin nfail++; $display("[TB] FAIL blankpress_next_adv: got %0b expected %0b", a, BLANK_EN); end
    endtask

    task automatic test_press_on_expire();
        pattern_t s;
        logic b, a, a2;
        int base;
        do_reset(1'b1);
        base = adv_seen;
        for (int f = 1; f <= 3; f++) frame(0, s, b, a, a2);
        press(20, 20);
        frame(40, s, b, a, a2);
        nchk++; if (s !== 2'd1) begin nfail++; $display("[TB] FAIL expire_sel: got %0d expected 1", s); end
        frame(0, s, b, a, a2);
        nchk++; if (s !== 2'd1) begin nfail++; $display("[TB] FAIL expire_hold_sel: got %0d expected 1", s); end
        nchk++; if (adv_seen - base !== 1) begin nfail++; $display("[TB] FAIL expire_adv_count: got %0d expected 1", adv_seen - base); end
    endtask

    task automatic test_reset_mid_blank();
        pattern_t s;
        logic b, a, a2;
        logic exp_b;
        do_reset(1'b1);
        for (int f = 1; f <= 4; f++) frame(0, s, b, a, a2);
        tick(10);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        nchk++; if (bus.pattern_select !== 2'd0) begin nfail++; $display("[TB] FAIL async_rst_sel: got %0d expected 0", bus.pattern_select); end
        nchk++; if (bus.blank !== 1'b0) begin nfail++; $display("[TB] FAIL async_rst_blank: got %0b expected 0", bus.blank); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int f = 1; f <= 4; f++) begin
            frame(0, s, b, a, a2);
            exp_b = BLANK_EN && (f == 4);
            nchk++; if (s !== ((f == 4) ? 2'd1 : 2'd0)) begin nfail++; $display("[TB] FAIL rst_restart_sel f%0d: got %0d", f, s); end
            nchk++; if (a !== (f == 4)) begin nfail++; $display("[TB] FAIL rst_restart_adv f%0d: got %0b", f, a); end
            nchk++; if (b !== exp_b) begin nfail++; $display("[TB] FAIL rst_restart_blank f%0d: got %0b expected %0b", f, b, exp_b); end
        end
    endtask

    // Run all scenarios in order and report
    initial begin
        nchk  = 0;
        nfail = 0;
        rst_n = 1'b0;
        bus.next_frame = 1'b0;
        bus.btn_raw    = 1'b0;
        bus.auto_mode  = 1'b0;
        test_reset();
        test_auto_cycle();
        test_glitch_press();
        test_multi_press();
        test_press_during_blank();
        test_press_on_expire();
        test_reset_mid_blank();
        nchk++; if (midframe !== 0) begin nfail++; $display("[TB] FAIL midframe_changes: got %0d expected 0", midframe); end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/pattern_scheduler.md
# pattern_scheduler

Sequences the pattern generator multiplexer: drives `pattern_select` and a blanking flag so the display either auto-cycles through test patterns every N frames or steps on a debounced user button. All pattern changes are committed only on a frame boundary (`next_frame`), so a pattern never switches mid-frame. The block sits between the board I/O and the pattern selector, in the same clock domain as the VGA timing generator.

## Interface
Parameters:
- `NUM_PATTERNS`, 2: number of selectable patterns; select wraps from `NUM_PATTERNS-1` to 0 (range 2..4).
- `FRAMES_PER_PATTERN`, 120: frames each pattern is shown in auto mode (≥1).
- `BLANK_FRAMES`, 2: frames of forced black after each change (≥1; used only with blanking compiled in).
- `DEBOUNCE_CYCLES`, 250000: clock cycles the synchronised button must be stable before it is accepted (≥2).

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `next_frame` in 1: one-cycle pulse at the start of vertical blanking.
- `btn_raw` in 1: asynchronous, bouncing push-button, active-high.
- `auto_mode` in 1: 1 = timed auto-cycling, 0 = manual stepping; quasi-static level, synchronised internally.
- `pattern_select` out 2: registered pattern index to the selector.
- `blank` out 1: 1 = downstream forces rgb to 0.
- `advanced` out 1: one-cycle pulse in the cycle `pattern_select` changes.

## Operation
- Button path: 2-FF synchroniser, then debouncer. The debounced level updates after `DEBOUNCE_CYCLES` consecutive equal samples. A 0→1 transition of the debounced level produces `press` (1 cycle).
- `press` sets sticky `req`. `req` clears only when an advance is committed. Multiple presses before a boundary collapse to one advance.
- `auto_mode` is 2-FF synchronised. Manual mode ignores the frame counter. Auto mode also honours `req`.
- Frame counter `fcnt` (width clog2(`FRAMES_PER_PATTERN`)): increments on `next_frame` in SHOW while auto. It is held at 0 in manual mode and in BLANK. Any change of synced `auto_mode` clears it.
- `expire` = auto ∧ `fcnt`==`FRAMES_PER_PATTERN`-1.
- State machine, two states:
  - SHOW: on `next_frame` with (`req` ∨ `expire`): `pattern_select`←(sel+1) mod `NUM_PATTERNS`, `fcnt`←0, `req`←0, `advanced`=1, `blank`←1, go to BLANK with `bcnt`←0. If `req` and `expire` coincide, exactly one advance occurs.
  - BLANK: `bcnt` increments on each `next_frame`. On the `next_frame` where `bcnt`==`BLANK_FRAMES`-1, `blank`←0 and the state returns to SHOW. A `req` raised during BLANK stays pending and is committed on the first `next_frame` seen in SHOW (the one after blanking ends), not on the blank-ending pulse itself.
- Reset: `pattern_select`=0, `blank`=0, `advanced`=0, state SHOW, `fcnt`=0, `bcnt`=0, `req`=0, debounced level=0, synchroniser flops=0. Reset mid-debounce or mid-blank discards all progress.

## Timing
- `pattern_select`, `blank` and `advanced` are all registered and change in the cycle after the committing `next_frame` (latency 1). `advanced` is high for exactly that one cycle.
- Button to `req`: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles after a clean edge.
- `auto_mode` takes effect 2 cycles after it changes.
- Auto period: one advance every `FRAMES_PER_PATTERN` + `BLANK_FRAMES` frames, i.e. `FRAMES_PER_PATTERN` frames shown after blanking ends.

## Configuration
- `PATTERN_SCHED_BLANK_EN` defined: BLANK state and `bcnt` exist as described.
- Undefined: no BLANK state, and `blank` is tied 0. After an advance the block stays in SHOW, and the next commit can occur on the following `next_frame`.

## Structure
- Shared package `pattern_pkg`:
  - pattern index constants `PATTERN_CHECKERBOARD`=0, `PATTERN_RADIENT`=1
  - `pattern_t` as a 2-bit type
  - scheduler state encoding SHOW=0, BLANK=1
- One sub-module, `button_debounce`: synchroniser, stable-count debouncer and rising-edge pulse. It is parameterised by `DEBOUNCE_CYCLES` and uses the same `clk`/`rst_n`.

## Test plan
All scenarios use `NUM_PATTERNS`=2, `FRAMES_PER_PATTERN`=4, `BLANK_FRAMES`=2, `DEBOUNCE_CYCLES`=8, with `next_frame` every 50 cycles.
- Reset, auto=1, no button → sel 0 for 4 frames, then sel=1 with `advanced` pulse and `blank`=1 for 2 frames. After blank clears, sel stays 1 for 4 frames, then wraps to 0.
- Auto=0, 5-cycle button glitches then a clean 20-cycle press → no advance from the glitches. Exactly one advance (sel 0→1) is committed on the next `next_frame` after the accepted press, never mid-frame.
- Three clean presses within one frame, manual → a single advance only.
- Press accepted during BLANK → sel unchanged at the blank-ending `next_frame`. It advances at the following `next_frame`.
- Press expiring in the same frame as `fcnt`==3 in auto → exactly one increment and a single `advanced` pulse.
- `rst_n` low for 1 cycle mid-BLANK, asynchronously → `pattern_select`=0 and `blank`=0 immediately. `fcnt` restarts, and the first auto advance occurs after 4 frames. Without `PATTERN_SCHED_BLANK_EN`, `blank` stays 0 throughout.
